stream_result_checker: RTL and testbench
========================================

# stream_result_checker

Parametrised write-stream result checker for the CPU test environment. It snoops the core's data-memory write port and arms when the begin symbol is written to the test port. Each later write to the test port is compared against a runtime-loaded answer memory, and the block reports error count, cycle duration, first-failure details, pass/timeout and finish. It is the synthesisable, configurable successor of the fixed-ROM testbed checker and adds early termination on the end symbol and a watchdog.

## Interface
- ADDR_W, 30, word-address width of the snooped bus
- DATA_W, 32, data width; must be a multiple of 8
- DEPTH, 32, answer-memory entries; IDX_W = clog2(DEPTH), CNT_W = clog2(DEPTH+1)
- TEST_PORT, 30'h10, word address monitored
- BEGIN_SYM, 32'h00000168, arming symbol
- END_SYM, 32'hFFFFFD5D, end-of-stream symbol
- SWAP_EN, 1, 1 = byte-reverse data before compare (little-endian to readable)
- EARLY_END, 1, 1 = END_SYM terminates the check early
- TIMEOUT, 16'hFFFF, max CHECK cycles
- clk  in  1  clock; single clock domain, rising edge
- rst  in  1  synchronous, active-high reset
- addr  in  ADDR_W  snooped write address
- data  in  DATA_W  snooped write data
- wen  in  1  snooped write enable; may stay high for several cycles during a D-cache stall
- ans_we  in  1  answer-memory write strobe
- ans_addr  in  IDX_W  answer-memory write index
- ans_data  in  DATA_W  answer value, in readable (already swapped) format
- check_num  in  CNT_W  number of results expected; sampled on arming
- error_num  out  8  mismatch count; 8'hFF while idle
- duration  out  16  cycles spent in CHECK
- finish  out  1  high in REPORT
- pass  out  1  finish and error_num==0 and not timeout
- timeout  out  1  watchdog fired
- first_err_idx  out  IDX_W  index of the first mismatch
- first_err_data  out  DATA_W  received data (swapped) at the first mismatch

## Operation
- dm = byte-reversed data when SWAP_EN, else data.
- wen_q <= wen every cycle. Accepted write acc = wen & ~wen_q & (addr==TEST_PORT). A held wen therefore counts once.
- Answer memory: DEPTH x DATA_W. It is written whenever ans_we is high, in any state, and is not cleared by rst. The read is combinational at idx. A same-cycle write to idx is not seen by that cycle's compare.
- IDLE:
  - On acc with dm==BEGIN_SYM: go to CHECK.
  - Set error_num=0, duration=0, idx=0 and timeout=0.
  - Latch n = min(check_num, DEPTH).
- CHECK:
  - duration+1 every cycle, saturating at 16'hFFFF.
  - On acc: compare dm with ans_mem[idx], then idx+1.
  - On mismatch: error_num+1, saturating at 8'hFE. If this is the first mismatch, capture first_err_idx and first_err_data.
  - Early end: if EARLY_END and dm==END_SYM on an acc with idx+1<n, add n-(idx+1) missing results to error_num (saturating at 8'hFE) and go to REPORT.
  - Completion: when registered idx==n, go to REPORT next cycle. With n==0 this happens the cycle after arming.
  - Watchdog: when duration==TIMEOUT-1 and completion is not reached, set timeout=1 and go to REPORT. Completion takes priority over the watchdog.
- REPORT: all outputs held, finish=1. Only rst exits; a new BEGIN_SYM is ignored.
- Writes to other addresses are never counted.

## Timing
- Reset values: error_num=8'hFF, duration=0, finish=0, pass=0, timeout=0, first_err_idx all-ones, first_err_data=0, idx=0, wen_q=0, state IDLE.
- error_num and first_err_* update the cycle after the accepted write.
- finish rises exactly one cycle after idx reaches n, or one cycle after the early-end or timeout write/cycle.
- duration counts the arming cycle's successor through the last CHECK cycle inclusive.
- rst during any state aborts to IDLE next edge with reset values; answer memory is retained.

## Test plan
- Basic pass:
  - Load 19 answers (0x0000CCCC … 0x6C4EC6E4, END_SYM), set check_num=19.
  - Write BEGIN_SYM byte-swapped (0x68010000), then 19 correct swapped writes.
  - Required: finish, pass=1, error_num=0.
- Mismatch and stall filter:
  - Same run, but index 3 gets 0x12345678 with wen held 3 cycles.
  - Required: error_num=1, first_err_idx=3, first_err_data=0x12345678, 19 results counted.
- Early end:
  - check_num=19; send END_SYM as the 5th result (idx 4).
  - Required: error_num = 1 (mismatch) + 14 missing = 15, finish one cycle later.
- Timeout:
  - TIMEOUT=100, arm, then send only 2 results.
  - Required: timeout=1, pass=0, finish at duration=100.
- Boundaries:
  - check_num=0: finish one cycle after arming, pass=1.
  - 300 mismatches: error_num saturates at 0xFE.
  - rst mid-CHECK: outputs return to reset values, and a re-run passes with the same answers.
- Noise:
  - Writes to addr 0x11 and non-BEGIN writes in IDLE.
  - Required: no arming, no counting.

Source files
------------

// File: rtl/stream_result_checker.sv
// stream_result_checker
//   Snoops a data-memory write port. A write of BEGIN_SYM to TEST_PORT arms
//   the checker; every later accepted write to TEST_PORT is compared against
//   a runtime-loaded answer memory. Reports mismatch count, cycles spent
//   checking, first-failure details, pass/timeout and finish.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   addr, data, wen          snooped write bus (wen may be held during stalls)
//   ans_we/ans_addr/ans_data answer-memory load port (readable byte order)
//   check_num                number of results expected, sampled on arming
//   error_num .. first_err_data  result outputs, held while finish is high
module stream_result_checker #(
  parameter int                ADDR_W    = 30,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 32,
  parameter logic [ADDR_W-1:0] TEST_PORT = ADDR_W'('h10),
  parameter logic [DATA_W-1:0] BEGIN_SYM = DATA_W'(32'h00000168),
  parameter logic [DATA_W-1:0] END_SYM   = DATA_W'(32'hFFFFFD5D),
  parameter bit                SWAP_EN   = 1'b1,
  parameter bit                EARLY_END = 1'b1,
  parameter logic [15:0]       TIMEOUT   = 16'hFFFF,
  localparam int               IDX_W     = $clog2(DEPTH),
  localparam int               CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  input  logic              ans_we,
  input  logic [IDX_W-1:0]  ans_addr,
  input  logic [DATA_W-1:0] ans_data,
  input  logic [CNT_W-1:0]  check_num,
  output logic [7:0]        error_num,
  output logic [15:0]       duration,
  output logic              finish,
  output logic              pass,
  output logic              timeout,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_data
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REPORT} state_t;

  state_t            state_q, state_d;
  logic              wen_q, wen_d;
  logic [CNT_W-1:0]  idx_q, idx_d, n_q, n_d;
  logic [CNT_W-1:0]  idx_inc, n_lim;
  logic [7:0]        err_q, err_d, err_v;
  logic [15:0]       dur_q, dur_d;
  logic              to_q, to_d;
  logic [IDX_W-1:0]  fe_idx_q, fe_idx_d;
  logic [DATA_W-1:0] fe_data_q, fe_data_d;
  logic [DATA_W-1:0] ans_mem [DEPTH];
  logic [DATA_W-1:0] dm_swap, dm, ans_rd;
  logic              acc, done;

  // Add with saturation at 8'hFE; 8'hFF is reserved for "idle".
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W+8:0] s;
    s = (CNT_W+9)'(a) + (CNT_W+9)'(b);
    return (s > (CNT_W+9)'(254)) ? 8'hFE : s[7:0];
  endfunction

  always_comb begin
    for (int b = 0; b < DATA_W/8; b++) dm_swap[8*b +: 8] = data[DATA_W-8-8*b +: 8];
  end
  assign dm = SWAP_EN ? dm_swap : data;

  // Answer memory survives reset so a test can be re-run without reloading.
  always_ff @(posedge clk) begin
    if (ans_we) ans_mem[ans_addr] <= ans_data;
  end
  assign ans_rd = ans_mem[idx_q[IDX_W-1:0]];

  // Rising-edge detect on wen: a write held through a stall counts once.
  assign acc     = wen & ~wen_q & (addr == TEST_PORT);
  assign idx_inc = idx_q + 1'b1;
  assign done    = (idx_q == n_q);
  assign n_lim   = (check_num > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : check_num;

  always_comb begin
    state_d   = state_q;
    wen_d     = wen;
    idx_d     = idx_q;
    n_d       = n_q;
    err_d     = err_q;
    err_v     = err_q;
    dur_d     = dur_q;
    to_d      = to_q;
    fe_idx_d  = fe_idx_q;
    fe_data_d = fe_data_q;
    case (state_q)
      S_IDLE: begin
        if (acc && dm == BEGIN_SYM) begin
          state_d   = S_CHECK;
          err_d     = 8'h00;
          dur_d     = 16'h0000;
          idx_d     = '0;
          to_d      = 1'b0;
          n_d       = n_lim;
          fe_idx_d  = '1;
          fe_data_d = '0;
        end
      end
      S_CHECK: begin
        dur_d = (dur_q == 16'hFFFF) ? dur_q : dur_q + 16'd1;
        if (done) begin
          state_d = S_REPORT;
        end else begin
          if (acc) begin
            idx_d = idx_inc;
            if (dm != ans_rd) begin
              err_v = sat_add(err_q, CNT_W'(1));
              // err_q is still zero only until the first real mismatch
              if (err_q == 8'h00) begin
                fe_idx_d  = idx_q[IDX_W-1:0];
                fe_data_d = dm;
              end
            end
            if (EARLY_END && dm == END_SYM && idx_inc < n_q) begin
              err_v   = sat_add(err_v, n_q - idx_inc);
              state_d = S_REPORT;
            end
            err_d = err_v;
          end
          if (state_d == S_CHECK && dur_q == TIMEOUT - 16'd1) begin
            to_d    = 1'b1;
            state_d = S_REPORT;
          end
        end
      end
      default: ;  // S_REPORT: hold everything until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wen_q     <= 1'b0;
      idx_q     <= '0;
      n_q       <= '0;
      err_q     <= 8'hFF;
      dur_q     <= 16'h0000;
      to_q      <= 1'b0;
      fe_idx_q  <= '1;
      fe_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wen_q     <= wen_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      err_q     <= err_d;
      dur_q     <= dur_d;
      to_q      <= to_d;
      fe_idx_q  <= fe_idx_d;
      fe_data_q <= fe_data_d;
    end
  end

  assign error_num      = err_q;
  assign duration       = dur_q;
  assign finish         = (state_q == S_REPORT);
  assign pass           = finish & (err_q == 8'h00) & ~to_q;
  assign timeout        = to_q;
  assign first_err_idx  = fe_idx_q;
  assign first_err_data = fe_data_q;

endmodule

// File: tb/tb_stream_result_checker.sv
// Scoreboard bench for stream_result_checker. Two instances share the input
// bus: u1 (DEPTH=512, TIMEOUT=4000) and u2 (DEPTH=32, TIMEOUT=100). Each run
// pushes the expected final report per instance; monitors pop on finish rise.
module tb_stream_result_checker;
  localparam logic [31:0] BEGIN_SYM = 32'h00000168;
  localparam logic [31:0] END_SYM   = 32'hFFFFFD5D;
  localparam logic [29:0] TPORT     = 30'h10;
  localparam int          TO1 = 4000, TO2 = 100;

  typedef struct {
    logic [7:0]  err;
    logic [15:0] dur;
    logic        pass;
    logic        to;
    logic [8:0]  fidx;
    logic [31:0] fdata;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, wen = 1'b0, ans_we = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] data = '0, ans_data = '0;
  logic [8:0]  ans_addr = '0;
  logic [9:0]  check_num = '0;

  logic [7:0]  e1, e2;
  logic [15:0] d1, d2;
  logic        f1, f2, p1, p2, t1, t2;
  logic [8:0]  fi1;
  logic [4:0]  fi2;
  logic [31:0] fd1, fd2;

  int nerr = 0, nchk = 0, cyc = 0, e0 = 0;
  logic [31:0] ref_ans [512];
  logic [31:0] ref_ans2 [32];
  logic [31:0] stim[$];
  int          acc_e[$];
  exp_t        q1[$], q2[$];

  stream_result_checker #(.DEPTH(512), .TIMEOUT(16'(TO1))) u1 (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .ans_we(ans_we), .ans_addr(ans_addr), .ans_data(ans_data), .check_num(check_num),
    .error_num(e1), .duration(d1), .finish(f1), .pass(p1), .timeout(t1),
    .first_err_idx(fi1), .first_err_data(fd1));

  stream_result_checker #(.DEPTH(32), .TIMEOUT(16'(TO2))) u2 (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .ans_we(ans_we), .ans_addr(ans_addr[4:0]), .ans_data(ans_data), .check_num(check_num[5:0]),
    .error_num(e2), .duration(d2), .finish(f2), .pass(p2), .timeout(t2),
    .first_err_idx(fi2), .first_err_data(fd2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] swp(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [29:0] a, input logic [31:0] v, input int h, input int g);
    addr = a; data = swp(v); wen = 1'b1;
    repeat (h) tick();
    wen = 1'b0;
    repeat (g) tick();
  endtask

  task automatic load_ans(input int i, input logic [31:0] v);
    ans_we = 1'b1; ans_addr = 9'(i); ans_data = v;
    ref_ans[i] = v; ref_ans2[i % 32] = v;
    tick();
    ans_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " err1"}, 32'(e1), 32'hFF);  chk({tag, " err2"}, 32'(e2), 32'hFF);
    chk({tag, " dur1"}, 32'(d1), 32'h0);   chk({tag, " fin1"}, 32'(f1), 32'h0);
    chk({tag, " pass1"}, 32'(p1), 32'h0);  chk({tag, " to1"}, 32'(t1), 32'h0);
    chk({tag, " fidx1"}, 32'(fi1), 32'h1FF); chk({tag, " fdat1"}, fd1, 32'h0);
    chk({tag, " fin2"}, 32'(f2), 32'h0);   chk({tag, " fidx2"}, 32'(fi2), 32'h1F);
  endtask

  // Reference: walk the accepted results in order, applying the rules for
  // compare, early end, completion and watchdog in terms of CHECK cycle
  // numbers (cycle k of CHECK follows the arming edge by k edges).
  function automatic exp_t model(input int n, input int to_lim, input bit use2);
    exp_t x;
    int err = 0, kc;
    bit ended = 1'b0;
    logic [31:0] a;
    x.fidx = '1; x.fdata = '0; x.to = 1'b0; x.dur = '0;
    for (int i = 0; i < stim.size(); i++) begin
      if (i >= n || acc_e[i] - e0 > to_lim) break;
      a = use2 ? ref_ans2[i] : ref_ans[i];
      if (stim[i] != a) begin
        if (err == 0) begin x.fidx = 9'(i); x.fdata = stim[i]; end
        err++;
      end
      if (stim[i] == END_SYM && i + 1 < n) begin
        err += n - i - 1;
        x.dur = 16'(acc_e[i] - e0);
        ended = 1'b1;
        break;
      end
    end
    if (!ended) begin
      if (n == 0) kc = 1;
      else if (stim.size() >= n) kc = acc_e[n-1] + 1 - e0;
      else kc = to_lim + 1;
      if (kc <= to_lim) x.dur = 16'(kc);
      else begin x.to = 1'b1; x.dur = 16'(to_lim); end
    end
    x.err  = (err > 254) ? 8'hFE : 8'(err);
    x.pass = !x.to && err == 0;
    return x;
  endfunction

  task automatic wait_done();
    for (int k = 0; k < 6000 && (q1.size() != 0 || q2.size() != 0); k++) tick();
    chk("finish wait q1", 32'(q1.size()), 32'h0);
    chk("finish wait q2", 32'(q2.size()), 32'h0);
    q1.delete(); q2.delete();
  endtask

  // Plans the whole write schedule first so the expected report can be
  // queued before the DUT can possibly finish.
  task automatic run(input int cnum, input int hold_idx, input bit noisy, input int gmax);
    int g[$], h[$];
    bit nz[$];
    int t, garm, n1, n2;
    check_num = 10'(cnum);
    acc_e.delete();
    garm = $urandom_range(1, gmax);
    t = cyc + 1; e0 = t; t += 1 + garm;
    for (int i = 0; i < stim.size(); i++) begin
      g.push_back($urandom_range(1, gmax));
      h.push_back((i == hold_idx) ? 3 : 1);
      nz.push_back(noisy && $urandom_range(0, 1) == 1);
      if (nz[i]) t += 2;
      acc_e.push_back(t);
      t += h[i] + g[i];
    end
    n1 = (cnum > 512) ? 512 : cnum;
    n2 = ((cnum % 64) > 32) ? 32 : (cnum % 64);
    q1.push_back(model(n1, TO1, 1'b0));
    q2.push_back(model(n2, TO2, 1'b1));
    send(TPORT, BEGIN_SYM, 1, garm);
    for (int i = 0; i < stim.size(); i++) begin
      if (nz[i]) send(30'h11, $urandom(), 1, 1);
      send(TPORT, stim[i], h[i], g[i]);
    end
    wait_done();
  endtask

  task automatic basic_stim();
    stim.delete();
    for (int i = 0; i < 19; i++) stim.push_back(ref_ans[i]);
  endtask

  // Scoreboard monitors
  initial begin
    exp_t x;
    bit pf1 = 1'b0, pf2 = 1'b0;
    forever begin
      @(negedge clk);
      if (f1 && !pf1) begin
        if (q1.size() == 0) chk("u1 unexpected finish", 32'(f1), 32'h0);
        else begin
          x = q1.pop_front();
          chk("u1 error_num", 32'(e1), 32'(x.err));
          chk("u1 duration", 32'(d1), 32'(x.dur));
          chk("u1 pass", 32'(p1), 32'(x.pass));
          chk("u1 timeout", 32'(t1), 32'(x.to));
          chk("u1 first_err_idx", 32'(fi1), 32'(x.fidx));
          chk("u1 first_err_data", fd1, x.fdata);
        end
      end
      if (f2 && !pf2) begin
        if (q2.size() == 0) chk("u2 unexpected finish", 32'(f2), 32'h0);
        else begin
          x = q2.pop_front();
          chk("u2 error_num", 32'(e2), 32'(x.err));
          chk("u2 duration", 32'(d2), 32'(x.dur));
          chk("u2 pass", 32'(p2), 32'(x.pass));
          chk("u2 timeout", 32'(t2), 32'(x.to));
          chk("u2 first_err_idx", 32'(fi2), 32'(x.fidx[4:0]));
          chk("u2 first_err_data", fd2, x.fdata);
        end
      end
      pf1 = f1; pf2 = f2;
    end
  end

  initial begin
    repeat (3) tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    // noise while idle: wrong address, wrong symbol, held wen
    send(30'h11, BEGIN_SYM, 1, 1);
    send(TPORT, 32'h12345678, 3, 1);
    send(30'h0F, BEGIN_SYM, 1, 2);
    chk("idle noise err1", 32'(e1), 32'hFF);
    chk("idle noise dur1", 32'(d1), 32'h0);
    chk("idle noise err2", 32'(e2), 32'hFF);

    load_ans(0, 32'h0000CCCC);
    for (int i = 1; i < 17; i++) load_ans(i, $urandom() & 32'h7FFF_FFFF);
    load_ans(17, 32'h6C4EC6E4);
    load_ans(18, END_SYM);
    for (int i = 19; i < 32; i++) load_ans(i, $urandom() & 32'h7FFF_FFFF);

    // basic pass
    basic_stim();
    run(19, -1, 1'b0, 2);
    // REPORT ignores a new BEGIN
    send(TPORT, BEGIN_SYM, 1, 3);
    chk("report hold fin", 32'(f1), 32'h1);
    chk("report hold err", 32'(e1), 32'h0);
    do_reset();

    // mismatch at idx 3, held 3 cycles, with noise writes
    basic_stim();
    stim[3] = 32'h12345678;
    run(19, 3, 1'b1, 3);
    do_reset();

    // early end at idx 4
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(ref_ans[i]);
    stim.push_back(END_SYM);
    run(19, -1, 1'b1, 2);
    do_reset();

    // watchdog: only 2 results
    stim.delete();
    stim.push_back(ref_ans[0]); stim.push_back(ref_ans[1]);
    run(19, -1, 1'b0, 2);
    do_reset();

    // check_num = 0
    stim.delete();
    run(0, -1, 1'b0, 1);
    do_reset();

    // reset mid-CHECK, then re-run
    check_num = 10'd19;
    send(TPORT, BEGIN_SYM, 1, 1);
    send(TPORT, ref_ans[0], 1, 1);
    send(TPORT, 32'hDEADBEEF, 1, 1);
    rst = 1'b1; tick();
    chk_reset("midrun");
    rst = 1'b0; tick();
    basic_stim();
    run(19, -1, 1'b0, 2);
    do_reset();

    // random runs
    for (int r = 0; r < 4; r++) begin
      int cn;
      cn = $urandom_range(1, 25);
      stim.delete();
      for (int i = 0; i < cn; i++)
        stim.push_back(($urandom_range(0, 3) == 0) ? ($urandom() & 32'h7FFF_FFFF) : ref_ans[i]);
      run(cn, $urandom_range(0, cn - 1), 1'b1, 3);
      do_reset();
    end

    // 300 mismatches saturate error_num
    for (int i = 0; i < 300; i++) load_ans(i, 32'(i));
    stim.delete();
    for (int i = 0; i < 300; i++) stim.push_back(32'hA500_0000 | 32'(i));
    run(300, -1, 1'b0, 1);
    do_reset();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
